puf_response_collector: RTL and testbench

//  Downstream consumer of the 256:1 PUF bit-select mux. Walks a sequence of mux

---
 rtl/puf_response_collector_if.sv | 29 ++
 rtl/puf_response_collector.sv | 104 ++++++++++
 tb/tb_puf_response_collector.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/puf_response_collector_if.sv
// Handshake/bus bundle between the PUF response collector, its mux and its consumer.
// The collector uses the slave modport; the surrounding logic drives the master side.
interface puf_response_collector_if #(
    parameter int unsigned RESP_W = 32,
    parameter int unsigned SEL_W  = 8
);
    localparam int unsigned UNST_W = $clog2(RESP_W + 1);

    logic              i_Start;
    logic [SEL_W-1:0]  i_Challenge;
    logic [SEL_W-1:0]  i_Stride;
    logic [SEL_W-1:0]  o_Sel;
    logic              i_Q;
    logic              o_Busy;
    logic              o_Valid;
    logic              i_Ready;
    logic [RESP_W-1:0] o_Resp;
    logic [UNST_W-1:0] o_Unstable;

    modport slave (
        input  i_Start, i_Challenge, i_Stride, i_Q, i_Ready,
        output o_Sel, o_Busy, o_Valid, o_Resp, o_Unstable
    );

    modport master (
        output i_Start, i_Challenge, i_Stride, i_Q, i_Ready,
        input  o_Sel, o_Busy, o_Valid, o_Resp, o_Unstable
    );
endinterface

// File: rtl/puf_response_collector.sv
// Walks mux addresses from a challenge, majority-votes each selected PUF bit and
// packs the votes MSB-first into a response word delivered on valid/ready.
module puf_response_collector #(
    parameter int unsigned RESP_W = 32,
    parameter int unsigned SEL_W  = 8,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned VOTES  = 5
) (
    input logic                     i_Clk,
    input logic                     i_Rst_n,
    puf_response_collector_if.slave bus
);
    localparam int unsigned UN_W    = $clog2(RESP_W + 1);
    localparam int unsigned OC_W    = $clog2(VOTES + 1);
    localparam int unsigned CNT_MAX = (SETTLE > VOTES) ? SETTLE : VOTES;
    localparam int unsigned WC_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned BC_W    = $clog2(RESP_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state;
    logic [SEL_W-1:0]  stride;
    logic [WC_W-1:0]   wait_cnt;
    logic [OC_W-1:0]   ones_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic              vote_bit;
    logic              split_vote;

    assign vote_bit   = (ones_cnt > OC_W'(VOTES / 2));
    assign split_vote = (ones_cnt != '0) && (ones_cnt != OC_W'(VOTES));

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state          <= S_IDLE;
            bus.o_Sel      <= '0;
            bus.o_Resp     <= '0;
            bus.o_Unstable <= '0;
            stride         <= '0;
            wait_cnt       <= '0;
            ones_cnt       <= '0;
            bit_cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_Start) begin
                        bus.o_Sel      <= bus.i_Challenge;
                        stride         <= bus.i_Stride;
                        bus.o_Resp     <= '0;
                        bus.o_Unstable <= '0;
                        bit_cnt        <= '0;
                        ones_cnt       <= '0;
                        wait_cnt       <= '0;
                        state          <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (wait_cnt == WC_W'(SETTLE - 1)) begin
                        wait_cnt <= '0;
                        state    <= S_SAMPLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    ones_cnt <= ones_cnt + OC_W'(bus.i_Q);
                    if (wait_cnt == WC_W'(VOTES - 1)) begin
                        wait_cnt <= '0;
                        state    <= S_SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    bus.o_Resp <= {bus.o_Resp[RESP_W-2:0], vote_bit};
                    if (split_vote)
                        bus.o_Unstable <= bus.o_Unstable + UN_W'(1);
                    bus.o_Sel <= bus.o_Sel + stride;
                    ones_cnt  <= '0;
                    if (bit_cnt == BC_W'(RESP_W - 1)) begin
                        state <= S_DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    // o_Valid is high throughout DONE, so Ready alone completes the handshake
                    if (bus.i_Ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_Busy  = (state == S_SETTLE) || (state == S_SAMPLE) || (state == S_SHIFT);
    assign bus.o_Valid = (state == S_DONE);
endmodule

// File: tb/tb_puf_response_collector.sv
// Randomized directed bench for puf_response_collector against a per-address vote-mask
// mux model; expected words come from summing each address's votes arithmetically.
module tb_puf_response_collector;
    localparam int unsigned RESP_W = 32;
    localparam int unsigned SEL_W  = 8;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned VOTES  = 5;
    localparam int unsigned PER    = SETTLE + VOTES + 1;
    // o_Valid is first seen after this many edges, counting the accepting edge as the first
    localparam int unsigned LAT    = RESP_W * PER + 1;
    localparam int unsigned NADDR  = 1 << SEL_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    // Vote pattern per mux address: bit k is i_Q during the k-th sample window cycle
    logic [VOTES-1:0] mask [NADDR];

    puf_response_collector_if #(.RESP_W(RESP_W), .SEL_W(SEL_W)) bus ();

    puf_response_collector #(
        .RESP_W(RESP_W),
        .SEL_W (SEL_W),
        .SETTLE(SETTLE),
        .VOTES (VOTES)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [SEL_W-1:0] ch, input logic [SEL_W-1:0] st,
                                  output logic [RESP_W-1:0] resp, output int unsigned unst,
                                  output logic [SEL_W-1:0] next_sel);
        int unsigned a, pc;
        resp = '0;
        unst = 0;
        for (int unsigned i = 0; i < RESP_W; i++) begin
            a  = (int'(ch) + i * int'(st)) % NADDR;
            pc = $countones(mask[a]);
            resp = {resp[RESP_W-2:0], 1'(pc > VOTES / 2)};
            if (pc > 0 && pc < VOTES) unst++;
        end
        next_sel = SEL_W'((int'(ch) + RESP_W * int'(st)) % NADDR);
    endfunction

    task automatic collect(input string tag, input logic [SEL_W-1:0] ch, input logic [SEL_W-1:0] st,
                           input int hold, input bit use_lit, input logic [RESP_W-1:0] lit_resp,
                           input int lit_unst);
        logic [RESP_W-1:0] er;
        int unsigned       eu;
        logic [SEL_W-1:0]  es;
        int                edges;
        int unsigned       p;
        bit                got;
        model(ch, st, er, eu, es);
        @(negedge clk);
        bus.i_Start     = 1'b1;
        bus.i_Challenge = ch;
        bus.i_Stride    = st;
        bus.i_Ready     = 1'($urandom);
        @(posedge clk);
        edges = 1;
        got   = 1'b0;
        for (int unsigned cyc = 0; cyc < LAT + 20; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                chk({tag, "/busy_after_start"}, 64'(bus.o_Busy), 64'(1));
                chk({tag, "/sel_is_challenge"}, 64'(bus.o_Sel), 64'(ch));
            end
            if (bus.o_Valid) begin
                got = 1'b1;
                break;
            end
            p = cyc % PER;
            if (p >= SETTLE && p < SETTLE + VOTES)
                bus.i_Q = mask[bus.o_Sel][p-SETTLE];
            else
                bus.i_Q = 1'($urandom);
            bus.i_Start     = 1'($urandom);
            bus.i_Challenge = SEL_W'($urandom);
            bus.i_Stride    = SEL_W'($urandom);
            bus.i_Ready     = 1'($urandom);
            @(posedge clk);
            edges++;
        end
        bus.i_Start = 1'b0;
        bus.i_Ready = 1'b0;
        chk({tag, "/valid_seen"}, 64'(got), 64'(1));
        chk({tag, "/latency"}, 64'(edges), 64'(LAT));
        chk({tag, "/resp"}, 64'(bus.o_Resp), 64'(er));
        chk({tag, "/unstable"}, 64'(bus.o_Unstable), 64'(eu));
        chk({tag, "/sel_next_unused"}, 64'(bus.o_Sel), 64'(es));
        chk({tag, "/busy_in_done"}, 64'(bus.o_Busy), 64'(0));
        if (use_lit) begin
            chk({tag, "/resp_known"}, 64'(bus.o_Resp), 64'(lit_resp));
            chk({tag, "/unstable_known"}, 64'(bus.o_Unstable), 64'(lit_unst));
        end
        if (got) begin
            for (int k = 0; k < hold; k++) begin
                bus.i_Start     = 1'($urandom);
                bus.i_Challenge = SEL_W'($urandom);
                bus.i_Q         = 1'($urandom);
                @(posedge clk);
                @(negedge clk);
                chk({tag, "/hold_valid"}, 64'(bus.o_Valid), 64'(1));
                chk({tag, "/hold_resp"}, 64'(bus.o_Resp), 64'(er));
                chk({tag, "/hold_unstable"}, 64'(bus.o_Unstable), 64'(eu));
                chk({tag, "/hold_sel"}, 64'(bus.o_Sel), 64'(es));
            end
            // Start asserted in the handshake cycle itself must be ignored
            bus.i_Ready = 1'b1;
            bus.i_Start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.i_Ready = 1'b0;
            bus.i_Start = 1'b0;
            chk({tag, "/valid_drops"}, 64'(bus.o_Valid), 64'(0));
            chk({tag, "/idle_after_hs"}, 64'(bus.o_Busy), 64'(0));
            @(posedge clk);
            @(negedge clk);
            chk({tag, "/hs_start_ignored"}, 64'(bus.o_Busy), 64'(0));
        end
    endtask

    task automatic reset_mid_collection();
        int unsigned p;
        int          vcount;
        @(negedge clk);
        bus.i_Start     = 1'b1;
        bus.i_Challenge = SEL_W'($urandom);
        bus.i_Stride    = SEL_W'($urandom);
        @(posedge clk);
        for (int unsigned cyc = 0; cyc < 98; cyc++) begin
            @(negedge clk);
            bus.i_Start = 1'b0;
            p = cyc % PER;
            bus.i_Q = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        chk("rst/busy_before", 64'(bus.o_Busy), 64'(1));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst/sel", 64'(bus.o_Sel), 64'(0));
        chk("rst/resp", 64'(bus.o_Resp), 64'(0));
        chk("rst/unstable", 64'(bus.o_Unstable), 64'(0));
        chk("rst/busy", 64'(bus.o_Busy), 64'(0));
        chk("rst/valid", 64'(bus.o_Valid), 64'(0));
        vcount = 0;
        for (int unsigned cyc = 0; cyc < LAT + 20; cyc++) begin
            bus.i_Q     = 1'($urandom);
            bus.i_Ready = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (bus.o_Valid || bus.o_Busy) vcount++;
        end
        bus.i_Ready = 1'b0;
        chk("rst/no_valid_after", 64'(vcount), 64'(0));
    endtask

    initial begin
        logic [SEL_W-1:0] ch, st;
        bus.i_Start     = 1'b0;
        bus.i_Challenge = '0;
        bus.i_Stride    = '0;
        bus.i_Q         = 1'b0;
        bus.i_Ready     = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset/sel", 64'(bus.o_Sel), 64'(0));
        chk("reset/resp", 64'(bus.o_Resp), 64'(0));
        chk("reset/unstable", 64'(bus.o_Unstable), 64'(0));
        chk("reset/busy", 64'(bus.o_Busy), 64'(0));
        chk("reset/valid", 64'(bus.o_Valid), 64'(0));
        rst_n = 1'b1;

        for (int a = 0; a < NADDR; a++) mask[a] = '1;
        collect("t1_all_ones", 8'h00, 8'h01, 0, 1'b1, 32'hFFFF_FFFF, 0);

        for (int a = 0; a < NADDR; a++) mask[a] = (a % 2 == 1) ? '1 : '0;
        collect("t2_sel_lsb", 8'h00, 8'h01, 0, 1'b1, 32'h5555_5555, 0);

        for (int a = 0; a < NADDR; a++) mask[a] = (a == 0) ? '1 : '0;
        collect("t3_wrap", 8'hF0, 8'h10, 0, 1'b1, 32'h4000_4000, 0);

        for (int a = 0; a < NADDR; a++) mask[a] = 5'b10101;
        collect("t4_noise_3of5", SEL_W'($urandom), 8'h01, 0, 1'b1, 32'hFFFF_FFFF, 32);

        for (int a = 0; a < NADDR; a++) mask[a] = 5'b00011;
        collect("t4_noise_2of5", SEL_W'($urandom), 8'h03, 0, 1'b1, 32'h0000_0000, 32);

        for (int a = 0; a < NADDR; a++) mask[a] = VOTES'($urandom);
        collect("t5_backpressure", SEL_W'($urandom), SEL_W'($urandom), 20, 1'b0, '0, 0);
        collect("t5_next_start", SEL_W'($urandom), SEL_W'($urandom), 0, 1'b0, '0, 0);

        collect("t6_stride0", SEL_W'($urandom), 8'h00, 2, 1'b0, '0, 0);
        for (int n = 0; n < 4; n++) begin
            for (int a = 0; a < NADDR; a++) mask[a] = VOTES'($urandom);
            ch = SEL_W'($urandom);
            st = SEL_W'($urandom);
            collect("t6_random", ch, st, int'($urandom_range(0, 5)), 1'b0, '0, 0);
        end

        reset_mid_collection();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
